// File: rtl/cbm2_pkg.sv
// Shared definitions for the CBM-II bus timing slice: bus ownership and the default
// slot count of a full Professional (P2) bus cycle.
package cbm2_pkg;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } bus_owner_t;

  localparam int CBM2_SLOTS = 32;

  // Slots per bus half: the Business (B2) bus runs twice as fast as P2.
  function automatic int halfSlots(input int slots, input logic isB2);
    return isB2 ? slots / 4 : slots / 2;
  endfunction

endpackage

// File: rtl/cbm2_bus_sequencer.sv
// CBM-II system bus sequencer: slices clk_sys into video/CPU bus halves, paces the
// 6509 and video chip, and issues one RAM request per half, stalling until it is acked.
module cbm2_bus_sequencer
  import cbm2_pkg::*;
#(
  parameter int SLOTS    = CBM2_SLOTS,
  parameter int REQ_SLOT = 1
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic model,
  input  logic vic_ba,
  input  logic cpu_rdy,
  input  logic ram_ack,
  output logic phase,
  output logic vidCycle,
  output logic cpuCycle,
  output logic ram_req,
  output logic cpu_ce,
  output logic vid_ce,
  output logic stalled
);

  localparam int SW = $clog2(SLOTS);

  localparam logic [SW-1:0] LAST_P2  = SW'(halfSlots(SLOTS, 1'b0) - 1);
  localparam logic [SW-1:0] LAST_B2  = SW'(halfSlots(SLOTS, 1'b1) - 1);
  localparam logic [SW-1:0] STALL_P2 = SW'(halfSlots(SLOTS, 1'b0) - 2);
  localparam logic [SW-1:0] STALL_B2 = SW'(halfSlots(SLOTS, 1'b1) - 2);
  localparam logic [SW-1:0] REQ_AT   = SW'(REQ_SLOT);

  logic [SW-1:0] slot;
  logic          started;
  logic          modelLat;
  logic          baLat;
  logic          pending;

  logic [SW-1:0] slotNext;
  logic [SW-1:0] lastSlot;
  logic [SW-1:0] lastSlotNext;
  logic [SW-1:0] stallSlot;
  logic          phaseNext;
  logic          modelNext;
  logic          baNext;
  logic          pendNext;
  logic          stallNext;
  logic          vidNext;
  bus_owner_t    ownerNext;

  always_comb begin
    lastSlot  = modelLat ? LAST_B2 : LAST_P2;
    stallSlot = modelLat ? STALL_B2 : STALL_P2;
    // A request opens an outstanding access; an ack retires it, even on the request clk.
    pendNext  = (pending | ram_req) & ~ram_ack;
    slotNext  = slot;
    phaseNext = phase;
    modelNext = modelLat;
    baNext    = baLat;
    stallNext = 1'b0;

    if (!started) begin
      // First clk out of reset presents slot 0 of the video half.
      slotNext  = '0;
      phaseNext = 1'b0;
      modelNext = model;
      baNext    = 1'b1;
    end else if (stalled) begin
      stallNext = ~ram_ack;
    end else if (slot == lastSlot) begin
      slotNext  = '0;
      phaseNext = ~phase;
      if (phase) begin
        modelNext = model;
      end else begin
        baNext = vic_ba;
      end
    end else begin
      slotNext  = slot + SW'(1);
      stallNext = pendNext && (slotNext == stallSlot);
    end

    lastSlotNext = modelNext ? LAST_B2 : LAST_P2;
    // VIC stealing only exists on the P2 bus; phi1 always belongs to video.
    vidNext   = ~phaseNext | (~modelNext & ~baNext);
    ownerNext = vidNext ? OWN_VID : OWN_CPU;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      started  <= 1'b0;
      slot     <= '0;
      phase    <= 1'b0;
      modelLat <= 1'b0;
      baLat    <= 1'b1;
      pending  <= 1'b0;
      stalled  <= 1'b0;
      vidCycle <= 1'b0;
      cpuCycle <= 1'b0;
      ram_req  <= 1'b0;
      cpu_ce   <= 1'b0;
      vid_ce   <= 1'b0;
    end else begin
      started  <= 1'b1;
      slot     <= slotNext;
      phase    <= phaseNext;
      modelLat <= modelNext;
      baLat    <= baNext;
      pending  <= pendNext;
      stalled  <= stallNext;
      vidCycle <= (ownerNext == OWN_VID);
      cpuCycle <= (ownerNext == OWN_CPU);
      ram_req  <= !stalled && (slotNext == REQ_AT);
      vid_ce   <= (slotNext == lastSlotNext);
      cpu_ce   <= (slotNext == lastSlotNext) && (ownerNext == OWN_CPU) && cpu_rdy;
    end
  end

endmodule

// File: tb/tb_cbm2_bus_sequencer.sv
// Randomized and directed bench for cbm2_bus_sequencer against a cycle-level
// behavioural model of the bus timing rules, plus period/count checks.
module tb_cbm2_bus_sequencer;
  import cbm2_pkg::*;

  localparam int SLOTS    = 32;
  localparam int REQ_SLOT = 1;

  logic clk_sys = 1'b0;
  logic reset, model, vic_ba, cpu_rdy, ram_ack;
  logic phase, vidCycle, cpuCycle, ram_req, cpu_ce, vid_ce, stalled;

  always #5 clk_sys = ~clk_sys;

  cbm2_bus_sequencer #(.SLOTS(SLOTS), .REQ_SLOT(REQ_SLOT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .model   (model),
    .vic_ba  (vic_ba),
    .cpu_rdy (cpu_rdy),
    .ram_ack (ram_ack),
    .phase   (phase),
    .vidCycle(vidCycle),
    .cpuCycle(cpuCycle),
    .ram_req (ram_req),
    .cpu_ce  (cpu_ce),
    .vid_ce  (vid_ce),
    .stalled (stalled)
  );

  int errCount   = 0;
  int checkCount = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model of the bus timing
  bit mRun, mPhase, mModel, mBa, mPend, mStall;
  bit eReq, eVid, eCpu, eCce, eVce;
  int mSlot;

  function automatic int halfOf(input bit isB2);
    return isB2 ? SLOTS / 4 : SLOTS / 2;
  endfunction

  task automatic modelEdge(input bit rst, input bit md, input bit ba, input bit rdy, input bit ack);
    bit held;
    if (rst) begin
      mRun = 0; mSlot = 0; mPhase = 0; mPend = 0; mStall = 0;
      eReq = 0; eVid = 0; eCpu = 0; eCce = 0; eVce = 0;
      return;
    end
    held  = 0;
    mPend = (mPend || eReq) && !ack;
    if (!mRun) begin
      mRun = 1; mSlot = 0; mPhase = 0; mModel = md; mBa = 1;
    end else if (mStall) begin
      held   = 1;
      mStall = mPend;
    end else if (mSlot == halfOf(mModel) - 1) begin
      if (mPhase) mModel = md;
      else        mBa    = ba;
      mPhase = !mPhase;
      mSlot  = 0;
    end else begin
      mSlot++;
      mStall = mPend && (mSlot == halfOf(mModel) - 2);
    end
    eVid = !mPhase || (!mModel && !mBa);
    eCpu = !eVid;
    eReq = !held && (mSlot == REQ_SLOT);
    eVce = (mSlot == halfOf(mModel) - 1);
    eCce = eVce && eCpu && rdy;
  endtask

  // Stimulus knobs and window statistics
  int ackDelay   = 2;
  int ackTimer   = -1;
  bit ackRandom  = 0;
  bit spurious   = 0;
  bit randInputs = 0;

  int cyc = 0;
  int nCce, nReq, nVce, nVid, nCpu, nStallCyc;
  int lastCce = -1, lastAck = -1, intervalExp = 0, ackLatExp = 0;

  task automatic step();
    bit sRst, sMd, sBa, sRdy, sAck;
    sRst = reset; sMd = model; sBa = vic_ba; sRdy = cpu_rdy; sAck = ram_ack;
    @(posedge clk_sys);
    #1;
    cyc++;
    if (sAck) lastAck = cyc - 1;
    modelEdge(sRst, sMd, sBa, sRdy, sAck);
    checkEq("phase",    phase,    mRun && mPhase);
    checkEq("vidCycle", vidCycle, eVid);
    checkEq("cpuCycle", cpuCycle, eCpu);
    checkEq("ram_req",  ram_req,  eReq);
    checkEq("cpu_ce",   cpu_ce,   eCce);
    checkEq("vid_ce",   vid_ce,   eVce);
    checkEq("stalled",  stalled,  mStall);
    if (!sRst) checkEq("one_owner", 32'(vidCycle) + 32'(cpuCycle), 1);

    if (cpu_ce) begin
      nCce++;
      if (intervalExp > 0 && lastCce >= 0) checkEq("cce_period", cyc - lastCce, intervalExp);
      if (ackLatExp > 0 && lastAck >= 0)   checkEq("ack_to_cce", cyc - lastAck, ackLatExp);
      lastCce = cyc;
    end
    if (ram_req)  nReq++;
    if (vid_ce)   nVce++;
    if (vidCycle) nVid++;
    if (cpuCycle) nCpu++;
    if (stalled)  nStallCyc++;

    // Drive the inputs for the next clk, acting as the SDRAM controller.
    ram_ack = 1'b0;
    if (reset) begin
      ackTimer = -1;
    end else begin
      if (ram_req) ackTimer = ackRandom ? int'($urandom_range(0, 20)) : ackDelay;
      if (ackTimer == 0) ram_ack = 1'b1;
      if (ackTimer >= 0) ackTimer--;
      if (spurious && $urandom_range(0, 15) == 0) ram_ack = 1'b1;
    end
    if (randInputs) begin
      vic_ba  = ($urandom_range(0, 3) != 0);
      cpu_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) model = ~model;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic startWindow(input int period, input int ackLat);
    nCce = 0; nReq = 0; nVce = 0; nVid = 0; nCpu = 0; nStallCyc = 0;
    lastCce = -1; intervalExp = period; ackLatExp = ackLat;
  endtask

  task automatic endWindow();
    intervalExp = 0; ackLatExp = 0;
  endtask

  initial begin
    int firstReq;
    reset = 1'b1; model = 1'b0; vic_ba = 1'b1; cpu_rdy = 1'b1; ram_ack = 1'b0;
    runCycles(3);
    reset = 1'b0;

    // P2 free-run: 32 clk period, one cpu_ce and two ram_req per period
    runCycles(64);
    startWindow(32, 0);
    runCycles(128);
    endWindow();
    checkEq("p2_cce_count", nCce, 4);
    checkEq("p2_req_count", nReq, 8);
    checkEq("p2_vce_count", nVce, 8);
    checkEq("p2_cpu_clks",  nCpu, 64);

    // VIC steals every CPU half
    vic_ba = 1'b0;
    runCycles(64);
    startWindow(0, 0);
    runCycles(64);
    endWindow();
    checkEq("steal_cce_count", nCce, 0);
    checkEq("steal_vce_count", nVce, 4);
    checkEq("steal_vid_clks",  nVid, 64);
    checkEq("steal_req_count", nReq, 4);

    // CPU held off by RDY for three bus cycles
    vic_ba = 1'b1; cpu_rdy = 1'b0;
    runCycles(64);
    startWindow(0, 0);
    runCycles(96);
    endWindow();
    checkEq("rdy_cce_count", nCce, 0);
    checkEq("rdy_req_count", nReq, 6);
    checkEq("rdy_cpu_clks",  nCpu, 48);

    // B2: 16 clk period, vic_ba has no effect
    cpu_rdy = 1'b1; model = 1'b1; vic_ba = 1'b0;
    runCycles(64);
    startWindow(16, 0);
    runCycles(64);
    endWindow();
    checkEq("b2_cce_count", nCce, 4);
    checkEq("b2_req_count", nReq, 8);
    checkEq("b2_vid_clks",  nVid, 32);

    // P2 with ack withheld 20 clk: each half grows by 8 stalled clks
    model = 1'b0; vic_ba = 1'b1; ackDelay = 20;
    runCycles(96);
    startWindow(48, 2);
    runCycles(96);
    endWindow();
    checkEq("stall_cce_count", nCce, 2);
    checkEq("stall_req_count", nReq, 4);
    checkEq("stall_clks",      nStallCyc, 32);

    // Randomized traffic: ack delays, spurious acks, RDY, BA and model changes
    ackDelay = 2; ackRandom = 1; spurious = 1; randInputs = 1;
    runCycles(3000);
    ackRandom = 0; spurious = 0; randInputs = 0;
    model = 1'b0; vic_ba = 1'b1; cpu_rdy = 1'b1;

    // Reset in the middle of a stall, then a late ack right after release
    ackDelay = 30;
    for (int i = 0; i < 200 && !stalled; i++) step();
    checkEq("reach_stall", stalled, 1);
    runCycles(3);
    reset = 1'b1;
    runCycles(4);
    checkEq("rst_vidCycle", vidCycle, 0);
    checkEq("rst_stalled",  stalled, 0);
    reset = 1'b0; ackDelay = 2; ackTimer = -1; ram_ack = 1'b1;
    firstReq = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ram_req && firstReq < 0) firstReq = i;
    end
    checkEq("first_req_after_reset", firstReq, REQ_SLOT);
    runCycles(64);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
